// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths and the slave FSM state encoding.
package wb_pkg;

  localparam int WB_ADR_W = 30;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_ram_array.sv
// Word-wide RAM with per-byte write enables and a registered read port.
// The read register doubles as the slave's dat_o and only loads on a read.
module wb_ram_array
  import wb_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [WB_SEL_W-1:0]   sel_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DAT_W-1:0]   dat_i,
  output logic [WB_DAT_W-1:0]   dat_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WB_DAT_W-1:0] r_mem [DEPTH];
  logic [WB_DAT_W-1:0] r_rdata;

  // Storage write, lane by lane; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < WB_SEL_W; i++) begin
        if (sel_i[i]) begin
          r_mem[adr_i][8*i +: 8] <= dat_i[8*i +: 8];
        end
      end
    end
  end

  // Read data register: holds its value between reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (re_i) begin
      r_rdata <= r_mem[adr_i];
    end
  end

  assign dat_o = r_rdata;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave RAM with programmable wait states.
// Define WB_RAM_SLAVE_ERR_EN to error-terminate accesses with nonzero address bits above the RAM.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 10,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WB_ADR_W-1:0] adr_i,
  input  logic [WB_DAT_W-1:0] dat_i,
  input  logic [WB_SEL_W-1:0] sel_i,
  input  logic                we_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  output logic [WB_DAT_W-1:0] dat_o,
  output logic                ack_o,
  output logic                err_o
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  wb_state_e           r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic [WB_ADR_W-1:0] r_adr;
  logic [WB_DAT_W-1:0] r_dat;
  logic [WB_SEL_W-1:0] r_sel;
  logic                r_we;
  logic                r_ack;
  logic                r_err;

  logic                w_go;
  logic                w_cap;
  logic                w_to_resp;
  logic                w_bad;
  logic [WB_ADR_W-1:0] w_t_adr;
  logic [WB_DAT_W-1:0] w_t_dat;
  logic [WB_SEL_W-1:0] w_t_sel;
  logic                w_t_we;
  logic                w_ram_we;
  logic                w_ram_re;

  assign w_go = cyc_i & stb_i;

  // With zero wait states the commit edge is the capture edge, so live inputs feed the RAM.
  assign w_t_adr = (r_state == WB_IDLE) ? adr_i : r_adr;
  assign w_t_dat = (r_state == WB_IDLE) ? dat_i : r_dat;
  assign w_t_sel = (r_state == WB_IDLE) ? sel_i : r_sel;
  assign w_t_we  = (r_state == WB_IDLE) ? we_i  : r_we;

`ifdef WB_RAM_SLAVE_ERR_EN
  assign w_bad = ((w_t_adr >> ADDR_WIDTH) != '0);
`else
  logic w_unused_hi;
  assign w_unused_hi = |(w_t_adr >> ADDR_WIDTH);
  assign w_bad       = 1'b0;
`endif

  // Next-state and transfer-control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    w_to_resp   = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (w_go) begin
          w_cap     = 1'b1;
          w_cnt_nxt = WS_INIT;
          if (WAIT_STATES == 0) begin
            w_state_nxt = WB_RESP;
            w_to_resp   = 1'b1;
          end else begin
            w_state_nxt = WB_WAIT;
          end
        end else begin
          w_state_nxt = WB_IDLE;
        end
      end
      WB_WAIT: begin
        if (!w_go) begin
          w_state_nxt = WB_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = WB_RESP;
          w_cnt_nxt   = 4'd0;
          w_to_resp   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      WB_RESP: begin
        w_state_nxt = WB_IDLE;
      end
      default: begin
        w_state_nxt = WB_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_ram_we = w_to_resp &  w_t_we & ~w_bad;
  assign w_ram_re = w_to_resp & ~w_t_we & ~w_bad;

  // FSM, wait counter and response pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= WB_IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_to_resp & ~w_bad;
      r_err   <= w_to_resp &  w_bad;
    end
  end

  // Request latches, loaded only on the capture edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_adr <= '0;
      r_dat <= '0;
      r_sel <= '0;
      r_we  <= 1'b0;
    end else if (w_cap) begin
      r_adr <= adr_i;
      r_dat <= dat_i;
      r_sel <= sel_i;
      r_we  <= we_i;
    end
  end

  wb_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we_i  (w_ram_we),
    .re_i  (w_ram_re),
    .sel_i (w_t_sel),
    .adr_i (w_t_adr[ADDR_WIDTH-1:0]),
    .dat_i (w_t_dat),
    .dat_o (dat_o)
  );

  assign ack_o = r_ack;
  assign err_o = r_err;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench: one WAIT_STATES=1 slave and one WAIT_STATES=0 slave on shared address/data.
module tb_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc1, stb1, cyc0, stb0;
  logic [31:0] dat1, dat0;
  logic        ack1, ack0, err1, err0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .sel_i(sel), .we_i(we),
    .cyc_i(cyc1), .stb_i(stb1), .dat_o(dat1), .ack_o(ack1), .err_o(err1)
  );

  wb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .sel_i(sel), .we_i(we),
    .cyc_i(cyc0), .stb_i(stb0), .dat_o(dat0), .ack_o(ack0), .err_o(err0)
  );

  // One bounded transfer on the chosen slave; lat counts edges from capture to ack/err.
  task automatic xfer(input bit d0, input bit w, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat,
                      output bit got_ack, output bit got_err);
    adr = a; wdat = d; sel = s; we = w;
    if (d0) begin cyc0 = 1'b1; stb0 = 1'b1; end
    else    begin cyc1 = 1'b1; stb1 = 1'b1; end
    lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = 32'h0;
    while (!got_ack && !got_err && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      got_ack = d0 ? ack0 : ack1;
      got_err = d0 ? err0 : err1;
      rd      = d0 ? dat0 : dat1;
    end
    cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc1 = 1'b0; stb1 = 1'b0; cyc0 = 1'b0; stb0 = 1'b0;
    adr = 30'h0; wdat = 32'h0; sel = 4'h0; we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b want 0", ack1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err1: got %b want 0", err1); end
    checks++; if (dat1 !== 32'h0) begin errors++; $display("FAIL reset_dat1: got %h want 00000000", dat1); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b want 0", ack0); end
    checks++; if (dat0 !== 32'h0) begin errors++; $display("FAIL reset_dat0: got %h want 00000000", dat0); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ws1_rw();
    logic [31:0] rd; int lat; bit ga, ge;
    xfer(1'b0, 1'b1, 30'h004, 32'hDEADBEEF, 4'hF, rd, lat, ga, ge);
    checks++; if (!ga || lat != 2) begin errors++; $display("FAIL ws1_write_lat: got ack=%0b lat=%0d want ack=1 lat=2", ga, lat); end
    xfer(1'b0, 1'b0, 30'h004, 32'h0, 4'h0, rd, lat, ga, ge);
    checks++; if (!ga || lat != 2) begin errors++; $display("FAIL ws1_read_lat: got ack=%0b lat=%0d want ack=1 lat=2", ga, lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ws1_read_data: got %h want deadbeef", rd); end
    checks++; if (dat1 !== 32'hDEADBEEF || ack1 !== 1'b0) begin
      errors++; $display("FAIL ws1_dat_hold: got dat=%h ack=%b want deadbeef/0", dat1, ack1); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lat; bit ga, ge;
    xfer(1'b0, 1'b1, 30'h020, 32'h11223344, 4'hF, rd, lat, ga, ge);
    xfer(1'b0, 1'b1, 30'h020, 32'hAABBCCDD, 4'b0101, rd, lat, ga, ge);
    xfer(1'b0, 1'b0, 30'h020, 32'h0, 4'h0, rd, lat, ga, ge);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_0101: got %h want 11bb33dd", rd); end
    xfer(1'b0, 1'b1, 30'h020, 32'hFFFFFFFF, 4'h0, rd, lat, ga, ge);
    checks++; if (!ga) begin errors++; $display("FAIL lanes_sel0_ack: got ack=%0b want 1", ga); end
    xfer(1'b0, 1'b0, 30'h020, 32'h0, 4'hF, rd, lat, ga, ge);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_sel0_data: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_latched_inputs();
    logic [31:0] rd; int lat; bit ga, ge;
    adr = 30'h030; wdat = 32'h5A5A5A5A; sel = 4'hF; we = 1'b1; cyc1 = 1'b1; stb1 = 1'b1;
    @(posedge clk); #1;
    adr = 30'h031; wdat = 32'h00000000; sel = 4'h0; we = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL latch_ack: got %b want 1", ack1); end
    cyc1 = 1'b0; stb1 = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, 30'h030, 32'h0, 4'hF, rd, lat, ga, ge);
    checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL latch_data: got %h want 5a5a5a5a", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int lat; bit ga, ge; bit seen;
    xfer(1'b0, 1'b1, 30'h010, 32'h0BADF00D, 4'hF, rd, lat, ga, ge);
    adr = 30'h010; wdat = 32'h12345678; sel = 4'hF; we = 1'b1; cyc1 = 1'b1; stb1 = 1'b1;
    @(posedge clk); #1;
    stb1 = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack1 !== 1'b0) seen = 1'b1;
    end
    cyc1 = 1'b0;
    checks++; if (seen) begin errors++; $display("FAIL abort_no_ack: got ack during abort want none"); end
    xfer(1'b0, 1'b0, 30'h010, 32'h0, 4'hF, rd, lat, ga, ge);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL abort_data: got %h want 0badf00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat; bit ga, ge;
    logic [31:0] vals [3];
    logic        exp_ack [5];
    vals[0] = 32'hA0A0A0A0; vals[1] = 32'hB1B1B1B1; vals[2] = 32'hC2C2C2C2;
    exp_ack[0] = 1'b1; exp_ack[1] = 1'b0; exp_ack[2] = 1'b1; exp_ack[3] = 1'b0; exp_ack[4] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, 1'b1, 30'(i), vals[i], 4'hF, rd, lat, ga, ge);
      checks++; if (!ga || lat != 1) begin errors++; $display("FAIL ws0_write_lat%0d: got ack=%0b lat=%0d want 1/1", i, ga, lat); end
    end
    adr = 30'h0; we = 1'b0; sel = 4'hF; cyc0 = 1'b1; stb0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (ack0 !== exp_ack[k]) begin errors++; $display("FAIL b2b_ack%0d: got %b want %b", k, ack0, exp_ack[k]); end
      if (exp_ack[k]) begin
        checks++; if (dat0 !== vals[k/2]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", k, dat0, vals[k/2]); end
        adr = 30'(k/2 + 1);
      end
    end
    cyc0 = 1'b0; stb0 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int lat; bit ga, ge;
    xfer(1'b0, 1'b1, 30'h000, 32'h01020304, 4'hF, rd, lat, ga, ge);
    xfer(1'b0, 1'b1, 30'h400, 32'hCAFEF00D, 4'hF, rd, lat, ga, ge);
`ifdef WB_RAM_SLAVE_ERR_EN
    checks++; if (ga || !ge) begin errors++; $display("FAIL wrap_err: got ack=%0b err=%0b want 0/1", ga, ge); end
    xfer(1'b0, 1'b0, 30'h000, 32'h0, 4'hF, rd, lat, ga, ge);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL wrap_data: got %h want 01020304", rd); end
`else
    checks++; if (!ga || ge) begin errors++; $display("FAIL wrap_ack: got ack=%0b err=%0b want 1/0", ga, ge); end
    xfer(1'b0, 1'b0, 30'h000, 32'h0, 4'hF, rd, lat, ga, ge);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_data: got %h want cafef00d", rd); end
`endif
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] rd; int lat; bit ga, ge;
    adr = 30'h040; wdat = 32'h77777777; sel = 4'hF; we = 1'b1; cyc1 = 1'b1; stb1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL rst_resp_pre: got ack %b want 1", ack1); end
    rst = 1'b1;
    #1;
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rst_resp_ack: got ack %b want 0", ack1); end
    cyc1 = 1'b0; stb1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (dat1 !== 32'h0) begin errors++; $display("FAIL rst_resp_dat: got %h want 00000000", dat1); end
    xfer(1'b0, 1'b0, 30'h040, 32'h0, 4'hF, rd, lat, ga, ge);
    checks++; if (!ga || lat != 2) begin errors++; $display("FAIL rst_resp_read_lat: got ack=%0b lat=%0d want 1/2", ga, lat); end
    checks++; if (rd !== 32'h77777777) begin errors++; $display("FAIL rst_resp_read_data: got %h want 77777777", rd); end
  endtask

  initial begin
    test_reset();
    test_ws1_rw();
    test_byte_lanes();
    test_latched_inputs();
    test_abort();
    test_back_to_back();
    test_wrap();
    test_reset_in_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
